// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, NOP word and the x0 index.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;
  localparam logic [4:0]  RegX0    = 5'd0;

  function automatic logic src_hit(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational load-use detector: a load in EX whose destination feeds the instruction in ID.
module pipeline_ctrl_hazard_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != RegX0) &&
                    (src_hit(id_uses_rs1, id_rs1, ex_rd) || src_hit(id_uses_rs2, id_rs2, ex_rd));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register sequencer: Mealy load/flush controls for stalls, flushes, memory waits and halt.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          id_uses_rs1,
  input  logic          id_uses_rs2,
  input  logic [4:0]    ex_rd,
  input  logic          ex_mem_read,
  input  logic          ex_branch_taken,
  input  logic          mem_req,
  input  logic          wb_halt,
  output logic          pc_load,
  output logic          ifid_load,
  output logic          idex_load,
  output logic          exmem_load,
  output logic          memwb_load,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          halted,
  output logic [CW-1:0] stall_cycles
);

  localparam int unsigned   CntW    = $clog2(MEM_LAT) + 1;
  localparam bit            HasWait = (MEM_LAT > 1);
  localparam logic [CntW-1:0] CntLoad = HasWait ? CntW'(MEM_LAT - 2) : '0;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   stall_q;
  logic            load_use;
  logic            advance;

  pipeline_ctrl_hazard_unit u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    advance    = 1'b0;
    halted     = 1'b0;
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    exmem_load = 1'b0;
    memwb_load = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    unique case (state_q)
      StRun: begin
        if (wb_halt) begin
          state_d = StHalt;
        end else if (HasWait && mem_req) begin
          state_d = StMemWait;
          cnt_d   = CntLoad;
        end else begin
          advance = 1'b1;
        end
      end
      StMemWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (wb_halt) begin
          state_d = StHalt;
        end else begin
          // Release cycle: the access is complete, so mem_req is not re-examined.
          state_d = StRun;
          advance = 1'b1;
        end
      end
      StHalt:  halted = 1'b1;
      default: state_d = StRun;
    endcase

    if (advance) begin
      exmem_load = 1'b1;
      memwb_load = 1'b1;
      idex_load  = 1'b1;
      if (ex_branch_taken) begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_load   = 1'b1;
        ifid_load = 1'b1;
      end
    end

    // Controls are forced inactive while reset is asserted.
    if (!rst) begin
      halted     = 1'b0;
      pc_load    = 1'b0;
      ifid_load  = 1'b0;
      idex_load  = 1'b0;
      exmem_load = 1'b0;
      memwb_load = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_load && (state_q != StHalt) && (stall_q != {CW{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench: DUT a (MEM_LAT=3, CW=4) and DUT b (MEM_LAT=1, CW=16) share one stimulus stream.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, wb_halt;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_fl, a_idex_fl, a_halted;
  logic [3:0]  a_stall;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_fl, b_idex_fl, b_halted;
  logic [15:0] b_stall;

  logic [4:0] a_loads, b_loads;
  logic [1:0] a_fl, b_fl;
  assign a_loads = {a_pc, a_ifid, a_idex, a_exmem, a_memwb};
  assign b_loads = {b_pc, b_ifid, b_idex, b_exmem, b_memwb};
  assign a_fl    = {a_ifid_fl, a_idex_fl};
  assign b_fl    = {b_ifid_fl, b_idex_fl};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_LAT(3), .CW(4)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .wb_halt(wb_halt),
    .pc_load(a_pc), .ifid_load(a_ifid), .idex_load(a_idex), .exmem_load(a_exmem),
    .memwb_load(a_memwb), .ifid_flush(a_ifid_fl), .idex_flush(a_idex_fl), .halted(a_halted),
    .stall_cycles(a_stall)
  );

  pipeline_ctrl #(.MEM_LAT(1), .CW(16)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .wb_halt(wb_halt),
    .pc_load(b_pc), .ifid_load(b_ifid), .idex_load(b_idex), .exmem_load(b_exmem),
    .memwb_load(b_memwb), .ifid_flush(b_ifid_fl), .idex_flush(b_idex_fl), .halted(b_halted),
    .stall_cycles(b_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic load_use_rs1(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; id_uses_rs1 = 1'b1;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    settle();
    check("rst_loads", 32'(a_loads), 32'h0);
    check("rst_stall", 32'(a_stall), 32'd0);
    step();
    rst = 1'b1;
    settle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #3;
    // T1: reset state
    check("t1_loads",  32'(a_loads), 32'h0);
    check("t1_flush",  32'(a_fl), 32'h0);
    check("t1_halted", 32'(a_halted), 32'h0);
    check("t1_stall",  32'(a_stall), 32'd0);
    step();
    rst = 1'b1;
    settle();
    check("t1_release_loads", 32'(a_loads), 32'h1f);

    // T2: load-use on rs1 stalls PC/IF-ID and bubbles ID/EX for one cycle
    step(); load_use_rs1(5'd5); settle();
    check("t2_lu_loads", 32'(a_loads), 32'h07);
    check("t2_lu_flush", 32'(a_fl), 32'h1);
    step(); idle(); settle();
    check("t2_after_loads", 32'(a_loads), 32'h1f);
    check("t2_stall_a", 32'(a_stall), 32'd1);
    check("t2_stall_b", 32'(b_stall), 32'd1);
    load_use_rs1(5'd0); settle();
    check("t2_x0_loads", 32'(a_loads), 32'h1f);
    check("t2_x0_flush", 32'(a_fl), 32'h0);
    // rs2 dependency, then a matching rs1 that is not actually read
    step(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; settle();
    check("t2_rs2_loads", 32'(a_loads), 32'h07);
    step(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; settle();
    check("t2_unused_loads", 32'(a_loads), 32'h1f);
    check("t2_stall_rs2", 32'(a_stall), 32'd2);

    // T3: branch overrides load-use
    step(); idle(); load_use_rs1(5'd3); ex_branch_taken = 1'b1; settle();
    check("t3_loads", 32'(a_loads), 32'h1f);
    check("t3_flush", 32'(a_fl), 32'h3);
    step(); idle(); settle();
    check("t3_stall", 32'(a_stall), 32'd2);

    // T4: MEM_LAT=3 freezes two cycles; MEM_LAT=1 never freezes
    mem_req = 1'b1; settle();
    check("t4_c0_a", 32'(a_loads), 32'h00);
    check("t4_c0_b", 32'(b_loads), 32'h1f);
    step(); settle();
    check("t4_c1_a", 32'(a_loads), 32'h00);
    check("t4_c1_b", 32'(b_loads), 32'h1f);
    step(); settle();
    check("t4_c2_a", 32'(a_loads), 32'h1f);
    step(); idle(); settle();
    check("t4_stall_a", 32'(a_stall), 32'd4);
    check("t4_stall_b", 32'(b_stall), 32'd2);

    // T6: 20 load-use stalls saturate the 4-bit counter
    load_use_rs1(5'd12);
    for (int i = 0; i < 20; i++) step();
    idle(); settle();
    check("t6_sat_a", 32'(a_stall), 32'd15);
    check("t6_nosat_b", 32'(b_stall), 32'd22);
    load_use_rs1(5'd12);
    step(); idle(); settle();
    check("t6_hold_a", 32'(a_stall), 32'd15);

    // T5: halt, then reset; mid-run reset also exercised here
    pulse_reset();
    wb_halt = 1'b1; settle();
    check("t5_halt_req_loads", 32'(a_loads), 32'h00);
    check("t5_halt_req_halted", 32'(a_halted), 32'h0);
    step(); idle(); settle();
    check("t5_halted", 32'(a_halted), 32'h1);
    for (int i = 0; i < 4; i++) begin
      mem_req = i[0]; ex_branch_taken = ~i[0]; load_use_rs1(5'(i + 1)); settle();
      check("t5_frozen_loads", 32'(a_loads), 32'h00);
      check("t5_still_halted", 32'(a_halted), 32'h1);
      step();
    end
    idle(); settle();
    check("t5_stall_frozen", 32'(a_stall), 32'd1);

    // wb_halt arriving on the MEM_WAIT release cycle
    pulse_reset();
    mem_req = 1'b1; settle();
    step(); settle();
    step(); wb_halt = 1'b1; settle();
    check("t5_rel_loads", 32'(a_loads), 32'h00);
    step(); idle(); settle();
    check("t5_rel_halted_a", 32'(a_halted), 32'h1);
    check("t5_rel_halted_b", 32'(b_halted), 32'h1);
    check("t5_rel_stall_a", 32'(a_stall), 32'd3);
    check("t5_rel_stall_b", 32'(b_stall), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
